// File: rtl/eth_smi_slave.sv
// MDIO/SMI (clause 22) management responder.
// MDC and MDIO are oversampled in the clk_mac domain. Every detected MDC rise
// advances the frame decoder, which turns frames into one-cycle register
// read/write strobes. On reads it also drives the turnaround bit and the data
// bits back onto MDIO.
module eth_smi_slave #(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter bit         BCAST_EN = 1'b1
) (
    input  logic        clk_mac,
    input  logic        rst,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_RDATA, S_WDATA
    } state_t;

    logic        mdc_s1, mdc_s2, mdc_d;
    logic        mdio_s1, mdio_s2;
    logic        rise, bit_v;

    state_t      state, state_n;
    logic [5:0]  pre_cnt, pre_cnt_n;
    logic [4:0]  bit_cnt, bit_cnt_n;
    logic        op_hi, op_hi_n;
    logic        is_rd, is_rd_n;
    logic [3:0]  phy_sh, phy_sh_n;
    logic [4:0]  phy_full;
    logic        phy_match;
    logic        rd_q;
    logic [15:0] rsh, rsh_n;
    logic        mdo_n, oe_n, wr_n, rd_n, ferr_n;
    logic [4:0]  addr_n;
    logic [15:0] wdata_n;

    // Two-flop synchronisers plus one history flop on MDC for edge detection
    always_ff @(posedge clk_mac) begin
        if (rst) begin
            mdc_s1  <= 1'b0;
            mdc_s2  <= 1'b0;
            mdc_d   <= 1'b0;
            mdio_s1 <= 1'b0;
            mdio_s2 <= 1'b0;
        end else begin
            mdc_s1  <= mdc_i;
            mdc_s2  <= mdc_s1;
            mdc_d   <= mdc_s2;
            mdio_s1 <= mdio_i;
            mdio_s2 <= mdio_s1;
        end
    end

    assign rise      = mdc_s2 & ~mdc_d;
    assign bit_v     = mdio_s2;
    assign phy_full  = {phy_sh, bit_v};
    assign phy_match = (phy_full == PHY_ADDR) || (BCAST_EN && (phy_full == 5'd0));

    // State and datapath registers
    always_ff @(posedge clk_mac) begin
        if (rst) begin
            state     <= S_PRE;
            pre_cnt   <= '0;
            bit_cnt   <= '0;
            op_hi     <= 1'b0;
            is_rd     <= 1'b0;
            phy_sh    <= '0;
            rd_q      <= 1'b0;
            rsh       <= '0;
            mdio_o    <= 1'b0;
            mdio_oe   <= 1'b0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            frame_err <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            state     <= state_n;
            pre_cnt   <= pre_cnt_n;
            bit_cnt   <= bit_cnt_n;
            op_hi     <= op_hi_n;
            is_rd     <= is_rd_n;
            phy_sh    <= phy_sh_n;
            rd_q      <= reg_rd;
            rsh       <= rsh_n;
            mdio_o    <= mdo_n;
            mdio_oe   <= oe_n;
            reg_wr    <= wr_n;
            reg_rd    <= rd_n;
            frame_err <= ferr_n;
            reg_addr  <= addr_n;
            reg_wdata <= wdata_n;
        end
    end

    // Frame decoder: everything advances only on a synchronised MDC rise
    always_comb begin
        state_n   = state;
        pre_cnt_n = pre_cnt;
        bit_cnt_n = bit_cnt;
        op_hi_n   = op_hi;
        is_rd_n   = is_rd;
        phy_sh_n  = phy_sh;
        rsh_n     = rsh;
        mdo_n     = mdio_o;
        oe_n      = mdio_oe;
        addr_n    = reg_addr;
        wdata_n   = reg_wdata;
        wr_n      = 1'b0;
        rd_n      = 1'b0;
        ferr_n    = 1'b0;

        // read data arrives the cycle after the strobe
        if (rd_q) rsh_n = reg_rdata;

        if (rise) begin
            case (state)
                S_PRE: begin
                    if (bit_v) begin
                        if (pre_cnt != 6'd32) pre_cnt_n = pre_cnt + 6'd1;
                    end else if (pre_cnt == 6'd32) begin
                        state_n   = S_ST;
                        pre_cnt_n = '0;
                    end else begin
                        pre_cnt_n = '0;
                    end
                end
                S_ST: begin
                    if (bit_v) begin
                        state_n   = S_OP;
                        bit_cnt_n = '0;
                    end else begin
                        ferr_n    = 1'b1;
                        state_n   = S_PRE;
                        pre_cnt_n = '0;
                    end
                end
                S_OP: begin
                    if (bit_cnt == 5'd0) begin
                        op_hi_n   = bit_v;
                        bit_cnt_n = 5'd1;
                    end else if (op_hi != bit_v) begin
                        // 10 = read, 01 = write
                        is_rd_n   = op_hi;
                        state_n   = S_PHYAD;
                        bit_cnt_n = '0;
                    end else begin
                        ferr_n    = 1'b1;
                        state_n   = S_PRE;
                        pre_cnt_n = '0;
                    end
                end
                S_PHYAD: begin
                    phy_sh_n = phy_full[3:0];
                    if (bit_cnt == 5'd4) begin
                        bit_cnt_n = '0;
                        if (phy_match) begin
                            state_n = S_REGAD;
                        end else begin
                            // someone else's frame: stay silent and resync
                            state_n   = S_PRE;
                            pre_cnt_n = '0;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 5'd1;
                    end
                end
                S_REGAD: begin
                    addr_n = {reg_addr[3:0], bit_v};
                    if (bit_cnt == 5'd4) begin
                        state_n   = S_TA;
                        bit_cnt_n = '0;
                        rd_n      = is_rd;
                    end else begin
                        bit_cnt_n = bit_cnt + 5'd1;
                    end
                end
                S_TA: begin
                    if (is_rd) begin
                        // second turnaround bit: we drive 0
                        oe_n      = 1'b1;
                        mdo_n     = 1'b0;
                        state_n   = S_RDATA;
                        bit_cnt_n = '0;
                    end else if (bit_cnt == 5'd1) begin
                        state_n   = S_WDATA;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = 5'd1;
                    end
                end
                S_RDATA: begin
                    if (bit_cnt == 5'd16) begin
                        oe_n      = 1'b0;
                        mdo_n     = 1'b0;
                        state_n   = S_PRE;
                        pre_cnt_n = '0;
                    end else begin
                        mdo_n     = rsh[15];
                        rsh_n     = {rsh[14:0], 1'b0};
                        bit_cnt_n = bit_cnt + 5'd1;
                    end
                end
                S_WDATA: begin
                    wdata_n = {reg_wdata[14:0], bit_v};
                    if (bit_cnt == 5'd15) begin
                        wr_n      = 1'b1;
                        state_n   = S_PRE;
                        pre_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 5'd1;
                    end
                end
                default: begin
                    state_n   = S_PRE;
                    pre_cnt_n = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_smi_slave.sv
// Directed bench for eth_smi_slave: station-side MDC/MDIO driver, a register
// responder that returns rd_val one cycle after reg_rd, and strobe counters.
module tb_eth_smi_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mdc_i = 1'b0;
    logic        mdio_i = 1'b1;
    logic        mdio_o, mdio_oe;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_wr, reg_rd;
    logic [15:0] reg_rdata = 16'hDEAD;
    logic        frame_err;

    logic [15:0] rd_val = 16'h0000;
    logic [31:0] oe_rec = '0, o_rec = '0;
    int          wr_cnt = 0, rd_cnt = 0, fe_cnt = 0, oe_cyc = 0, both_cnt = 0;
    int          n_vec = 0, n_err = 0;

    eth_smi_slave #(.PHY_ADDR(5'd1), .BCAST_EN(1'b1)) dut (
        .clk_mac   (clk),
        .rst       (rst),
        .mdc_i     (mdc_i),
        .mdio_i    (mdio_i),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // register file stand-in: data valid only in the cycle after reg_rd
    always @(posedge clk) reg_rdata <= reg_rd ? rd_val : 16'hDEAD;

    always @(negedge clk) begin
        if (reg_wr) wr_cnt++;
        if (reg_rd) rd_cnt++;
        if (frame_err) fe_cnt++;
        if (mdio_oe) oe_cyc++;
        if (reg_wr && reg_rd) both_cnt++;
    end

    // one MDC period per bit; station samples just before the falling edge
    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk); mdc_i = 1'b0; mdio_i = v[i];
            repeat (6) @(negedge clk);
            mdc_i = 1'b1;
            repeat (6) @(negedge clk);
            oe_rec = {oe_rec[30:0], mdio_oe};
            o_rec  = {o_rec[30:0], mdio_o};
        end
    endtask

    task automatic idle();
        @(negedge clk); mdc_i = 1'b0; mdio_i = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (mdio_oe !== 1'b0) begin n_err++; $display("FAIL rst_oe: got %b want 0", mdio_oe); end
        n_vec++; if (mdio_o !== 1'b0) begin n_err++; $display("FAIL rst_o: got %b want 0", mdio_o); end
        n_vec++; if (reg_wr !== 1'b0) begin n_err++; $display("FAIL rst_wr: got %b want 0", reg_wr); end
        n_vec++; if (reg_rd !== 1'b0) begin n_err++; $display("FAIL rst_rd: got %b want 0", reg_rd); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
        n_vec++; if (reg_addr !== 5'h00) begin n_err++; $display("FAIL rst_addr: got %h want 00", reg_addr); end
        n_vec++; if (reg_wdata !== 16'h0000) begin n_err++; $display("FAIL rst_wdata: got %h want 0000", reg_wdata); end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_write();
        int w0 = wr_cnt, r0 = rd_cnt, f0 = fe_cnt, e0 = oe_cyc;
        send_bits(64'hFFFF_FFFF, 32);
        send_bits({32'h0, 2'b01, 2'b01, 5'd1, 5'h04, 2'b10, 16'hA5C3}, 32);
        idle();
        n_vec++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL wr_count: got %0d want 1", wr_cnt - w0); end
        n_vec++; if (rd_cnt - r0 !== 0) begin n_err++; $display("FAIL wr_no_rd: got %0d want 0", rd_cnt - r0); end
        n_vec++; if (reg_addr !== 5'h04) begin n_err++; $display("FAIL wr_addr: got %h want 04", reg_addr); end
        n_vec++; if (reg_wdata !== 16'hA5C3) begin n_err++; $display("FAIL wr_data: got %h want a5c3", reg_wdata); end
        n_vec++; if (oe_cyc - e0 !== 0) begin n_err++; $display("FAIL wr_oe: got %0d want 0", oe_cyc - e0); end
        n_vec++; if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL wr_ferr: got %0d want 0", fe_cnt - f0); end
    endtask

    // full read frame; checks the strobe and the station-side view of MDIO
    task automatic do_read(input logic [4:0] phy, input logic [4:0] ra,
                           input logic [15:0] d, input string nm);
        int r0 = rd_cnt, w0 = wr_cnt;
        rd_val = d;
        send_bits(64'hFFFF_FFFF, 32);
        send_bits({32'h0, 2'b01, 2'b10, phy, ra, 18'h3FFFF}, 32);
        idle();
        n_vec++; if (rd_cnt - r0 !== 1) begin n_err++; $display("FAIL %s_rd_count: got %0d want 1", nm, rd_cnt - r0); end
        n_vec++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL %s_no_wr: got %0d want 0", nm, wr_cnt - w0); end
        n_vec++; if (reg_addr !== ra) begin n_err++; $display("FAIL %s_addr: got %h want %h", nm, reg_addr, ra); end
        n_vec++; if (oe_rec !== 32'h0003_FFFE) begin n_err++; $display("FAIL %s_oe_bits: got %h want 0003fffe", nm, oe_rec); end
        n_vec++; if (o_rec !== (32'(d) << 1)) begin n_err++; $display("FAIL %s_data_bits: got %h want %h", nm, o_rec, 32'(d) << 1); end
        n_vec++; if (mdio_oe !== 1'b0) begin n_err++; $display("FAIL %s_release: got %b want 0", nm, mdio_oe); end
    endtask

    task automatic test_read();
        do_read(5'd1, 5'h1F, 16'h8001, "rd");
    endtask

    task automatic test_phyad();
        int r0 = rd_cnt, e0 = oe_cyc, f0 = fe_cnt;
        rd_val = 16'h7777;
        send_bits(64'hFFFF_FFFF, 32);
        send_bits({32'h0, 2'b01, 2'b10, 5'd3, 5'h02, 18'h3FFFF}, 32);
        idle();
        n_vec++; if (rd_cnt - r0 !== 0) begin n_err++; $display("FAIL phy3_rd: got %0d want 0", rd_cnt - r0); end
        n_vec++; if (oe_cyc - e0 !== 0) begin n_err++; $display("FAIL phy3_oe: got %0d want 0", oe_cyc - e0); end
        n_vec++; if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL phy3_ferr: got %0d want 0", fe_cnt - f0); end
        do_read(5'd0, 5'h0A, 16'h1234, "bcast");
    endtask

    task automatic test_short_pre();
        int r0 = rd_cnt, w0 = wr_cnt, e0 = oe_cyc, f0 = fe_cnt;
        send_bits(64'hFFFF_FFFF, 31);
        send_bits({32'h0, 2'b01, 2'b10, 5'd1, 5'h03, 18'h3FFFF}, 32);
        idle();
        n_vec++; if (rd_cnt - r0 !== 0) begin n_err++; $display("FAIL short_rd: got %0d want 0", rd_cnt - r0); end
        n_vec++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL short_wr: got %0d want 0", wr_cnt - w0); end
        n_vec++; if (oe_cyc - e0 !== 0) begin n_err++; $display("FAIL short_oe: got %0d want 0", oe_cyc - e0); end
        n_vec++; if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL short_ferr: got %0d want 0", fe_cnt - f0); end
    endtask

    task automatic test_bad_op();
        int r0 = rd_cnt, w0 = wr_cnt, f0 = fe_cnt;
        send_bits(64'hFFFF_FFFF, 32);
        send_bits({50'h0, 2'b01, 2'b11, 5'd1, 5'h00}, 14);
        idle();
        n_vec++; if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL badop_ferr: got %0d want 1", fe_cnt - f0); end
        n_vec++; if (rd_cnt - r0 !== 0) begin n_err++; $display("FAIL badop_rd: got %0d want 0", rd_cnt - r0); end
        n_vec++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL badop_wr: got %0d want 0", wr_cnt - w0); end
    endtask

    task automatic test_reset_mid_read();
        int w0 = wr_cnt;
        rd_val = 16'hF00F;
        send_bits(64'hFFFF_FFFF, 32);
        // header, turnaround, then 8 data bits
        send_bits({32'h0, 2'b01, 2'b10, 5'd1, 5'h06, 18'h3FFFF} >> 9, 23);
        @(negedge clk); mdc_i = 1'b0;
        n_vec++; if (mdio_oe !== 1'b1) begin n_err++; $display("FAIL mid_driving: got %b want 1", mdio_oe); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (mdio_oe !== 1'b0) begin n_err++; $display("FAIL mid_rst_oe: got %b want 0", mdio_oe); end
        rst = 1'b0;
        idle();
        n_vec++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL mid_rst_wr: got %0d want 0", wr_cnt - w0); end
        do_read(5'd1, 5'h05, 16'hBEEF, "after_rst");
    endtask

    task automatic test_back_to_back();
        int w0 = wr_cnt;
        send_bits(64'hFFFF_FFFF, 32);
        send_bits({32'h0, 2'b01, 2'b01, 5'd1, 5'h12, 2'b10, 16'h5A5A}, 32);
        n_vec++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL b2b_wr: got %0d want 1", wr_cnt - w0); end
        n_vec++; if (reg_wdata !== 16'h5A5A) begin n_err++; $display("FAIL b2b_wdata: got %h want 5a5a", reg_wdata); end
        do_read(5'd1, 5'h12, 16'h0F0F, "b2b");
        n_vec++; if (reg_wdata !== 16'h5A5A) begin n_err++; $display("FAIL b2b_wdata_hold: got %h want 5a5a", reg_wdata); end
        n_vec++; if (both_cnt !== 0) begin n_err++; $display("FAIL rd_wr_overlap: got %0d want 0", both_cnt); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_phyad();
        test_short_pre();
        test_bad_op();
        test_reset_mid_read();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/eth_smi_slave.md
ETH_SMI_SLAVE -- requirements
Module: eth_smi_slave

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1, the PHY address this responder answers.
REQ-002 SHALL have parameter BCAST_EN, default 1; when 1, PHYAD 5'd0 is also accepted.
REQ-003 SHALL have port clk_mac  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mdc_i  input  1  management clock from the station, asynchronous to clk_mac.
REQ-006 SHALL have port mdio_i  input  1  MDIO line value, asynchronous.
REQ-007 SHALL have port mdio_o  output  1  MDIO drive value.
REQ-008 SHALL have port mdio_oe  output  1  MDIO drive enable; 0 = released (top level tristates).
REQ-009 SHALL have port reg_addr  output  5  register address of the current frame.
REQ-010 SHALL have port reg_wdata  output  16  write data.
REQ-011 SHALL have port reg_wr  output  1  one-cycle write strobe.
REQ-012 SHALL have port reg_rd  output  1  one-cycle read strobe.
REQ-013 SHALL have port reg_rdata  input  16  read data, valid exactly 1 cycle after reg_rd.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse on malformed frame.

Function
REQ-015 SHALL synchronise mdc_i and mdio_i through 2 flops each; "rise" = synced MDC 0->1 detected in one clk_mac cycle; the bit value is synced MDIO in that cycle.
REQ-016 SHALL act only on rises; no MDC timeout exists.
REQ-017 States: PRE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA.
REQ-018 PRE: count consecutive 1 bits, saturating at 32; a 0 with count<32 clears the count; a 0 with count=32 enters ST.
REQ-019 ST: bit 1 -> OP; bit 0 -> frame_err, PRE count 0.
REQ-020 OP: two bits MSB first; 01=write, 10=read; 00/11 -> frame_err, PRE count 0.
REQ-021 PHYAD: 5 bits MSB first; match = PHY_ADDR, or 0 with BCAST_EN=1; mismatch -> PRE count 0, no frame_err, never drives.
REQ-022 REGAD: 5 bits MSB first into reg_addr; on a read, reg_rd pulses the cycle after the rise sampling REGAD[0].
REQ-023 SHALL capture reg_rdata the cycle after reg_rd.
REQ-024 Read: rise R1 after REGAD[0] -> mdio_oe=1, mdio_o=0; rises R2..R17 -> mdio_o=D15..D0; rise R18 -> mdio_oe=0, PRE count 0.
REQ-025 mdio_o/mdio_oe SHALL change only in the cycle after a rise; mdio_oe is never 1 outside R1..R17.
REQ-026 Write: rises R1,R2 are TA, not checked; R3..R18 shift D15..D0 into reg_wdata; reg_wr pulses the cycle after R18; then PRE count 0.
REQ-027 reg_addr/reg_wdata SHALL hold until the next frame's REGAD/WDATA shifting.
REQ-028 reg_wr and reg_rd SHALL never assert together, nor for more than one cycle per frame.

Reset
REQ-029 In the cycle after rst=1: state PRE, count 0, mdio_oe=0, mdio_o=0, reg_wr=0, reg_rd=0, frame_err=0, reg_addr=0, reg_wdata=0, sync flops 0.
REQ-030 rst mid-frame (including during RDATA) SHALL abort with no strobe; the next frame needs a full 32-bit preamble.

Verification
REQ-031 Write frame, PHYAD 1, REGAD 0x04, data 0xA5C3 -> one reg_wr, reg_addr=0x04, reg_wdata=0xA5C3, mdio_oe never 1.
REQ-032 Read frame, PHYAD 1, REGAD 0x1F, reg_rdata=0x8001 -> one reg_rd; station samples on MDC falls 0 then 0x8001 MSB first; mdio_oe drops at R18.
REQ-033 Read to PHYAD 3 -> no strobes, mdio_oe stays 0; PHYAD 0 with BCAST_EN=1 -> answered.
REQ-034 31-one preamble then 01 -> ignored; OP=11 after valid preamble -> frame_err pulse, no strobe.
REQ-035 rst at data bit 8 of a read -> mdio_oe=0 next cycle; following full frame handled normally.
REQ-036 Back-to-back write then read with 32-bit preambles -> both handled, reg_rdata returned correctly.
